// File: rtl/sc_grid_monitor.sv
// sc_grid_monitor: classifies grid voltage/frequency samples as normal,
// unstable or critical. The raw class passes through an escalation debounce,
// a stepwise recovery hysteresis and a sample-loss watchdog. The filtered
// result drives grid_state for the charge FSM.
//
// Optional feature macro: SC_GRID_EVENT_CNT_EN adds crit_events[7:0], a
// saturating count of entries into CRITICAL (escalation or watchdog).
//
// Input qualification: sample_valid marks volt_sample/freq_sample as valid
// for exactly the cycle it is high. There is no back-pressure; every valid
// sample is accepted on the clock edge that sees it.
//
// The filter FSM state register is grid_state itself, so the FSM state is
// always directly observable on that port.
module sc_grid_monitor #(
  parameter int VW          = 9,
  parameter int FW          = 13,
  parameter int V_NORM_LO   = 207,
  parameter int V_NORM_HI   = 253,
  parameter int V_CRIT_LO   = 180,
  parameter int V_CRIT_HI   = 270,
  parameter int F_NORM_LO   = 4950,
  parameter int F_NORM_HI   = 5050,
  parameter int F_CRIT_LO   = 4800,
  parameter int F_CRIT_HI   = 5200,
  parameter int ESC_CNT     = 3,
  parameter int REC_CNT     = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          sample_valid,
  input  logic [VW-1:0] volt_sample,
  input  logic [FW-1:0] freq_sample,
  output logic [1:0]    grid_state,
  output logic [1:0]    raw_class,
  output logic          state_change,
`ifdef SC_GRID_EVENT_CNT_EN
  output logic          timeout_flag,
  output logic [7:0]    crit_events
`else
  output logic          timeout_flag
`endif
);

  localparam logic [1:0] GRID_NORMAL   = 2'd0;
  localparam logic [1:0] GRID_UNSTABLE = 2'd1;
  localparam logic [1:0] GRID_CRITICAL = 2'd2;

  localparam int EW = $clog2(ESC_CNT + 1);
  localparam int RW = $clog2(REC_CNT + 1);
  localparam int IW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [VW-1:0] VNL = VW'(V_NORM_LO);
  localparam logic [VW-1:0] VNH = VW'(V_NORM_HI);
  localparam logic [VW-1:0] VCL = VW'(V_CRIT_LO);
  localparam logic [VW-1:0] VCH = VW'(V_CRIT_HI);
  localparam logic [FW-1:0] FNL = FW'(F_NORM_LO);
  localparam logic [FW-1:0] FNH = FW'(F_NORM_HI);
  localparam logic [FW-1:0] FCL = FW'(F_CRIT_LO);
  localparam logic [FW-1:0] FCH = FW'(F_CRIT_HI);

  localparam logic [EW-1:0] ESC_LIM  = EW'(ESC_CNT);
  localparam logic [RW-1:0] REC_LIM  = RW'(REC_CNT);
  localparam logic [IW-1:0] IDLE_LIM = IW'(TIMEOUT_CYC);

  logic [EW-1:0] esc_cnt, esc_nxt, esc_inc;
  logic [RW-1:0] rec_cnt, rec_nxt, rec_inc;
  logic [IW-1:0] idle_cnt, idle_nxt, idle_inc;
  logic [1:0]    state_nxt, raw_nxt, raw_now;
  logic          tflag_nxt;
  logic          is_crit, is_norm;

  assign esc_inc  = esc_cnt + EW'(1);
  assign rec_inc  = rec_cnt + RW'(1);
  assign idle_inc = idle_cnt + IW'(1);

  // Raw classification of the sample currently on the inputs.
  always_comb begin
    is_crit = (volt_sample < VCL) || (volt_sample > VCH) ||
              (freq_sample < FCL) || (freq_sample > FCH);
    is_norm = (volt_sample >= VNL) && (volt_sample <= VNH) &&
              (freq_sample >= FNL) && (freq_sample <= FNH);
    if (is_crit)      raw_now = GRID_CRITICAL;
    else if (is_norm) raw_now = GRID_NORMAL;
    else              raw_now = GRID_UNSTABLE;
  end

  // Filter FSM and watchdog next-state; a sample always beats a watchdog trip.
  always_comb begin
    state_nxt = grid_state;
    esc_nxt   = esc_cnt;
    rec_nxt   = rec_cnt;
    idle_nxt  = idle_cnt;
    tflag_nxt = timeout_flag;
    raw_nxt   = raw_class;
    if (sample_valid) begin
      idle_nxt  = '0;
      tflag_nxt = 1'b0;
      raw_nxt   = raw_now;
      if (raw_now > grid_state) begin
        rec_nxt = '0;
        if (esc_inc == ESC_LIM) begin
          state_nxt = raw_now;
          esc_nxt   = '0;
        end else begin
          esc_nxt = esc_inc;
        end
      end else if (raw_now < grid_state) begin
        esc_nxt = '0;
        if (rec_inc == REC_LIM) begin
          state_nxt = grid_state - 2'd1;
          rec_nxt   = '0;
        end else begin
          rec_nxt = rec_inc;
        end
      end else begin
        esc_nxt = '0;
        rec_nxt = '0;
      end
    end else if (idle_cnt != IDLE_LIM) begin
      idle_nxt = idle_inc;
      if (idle_inc == IDLE_LIM) begin
        state_nxt = GRID_CRITICAL;
        esc_nxt   = '0;
        rec_nxt   = '0;
        tflag_nxt = 1'b1;
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grid_state   <= GRID_UNSTABLE;
      raw_class    <= GRID_UNSTABLE;
      state_change <= 1'b0;
      timeout_flag <= 1'b0;
      esc_cnt      <= '0;
      rec_cnt      <= '0;
      idle_cnt     <= '0;
    end else begin
      grid_state   <= state_nxt;
      raw_class    <= raw_nxt;
      state_change <= (state_nxt != grid_state);
      timeout_flag <= tflag_nxt;
      esc_cnt      <= esc_nxt;
      rec_cnt      <= rec_nxt;
      idle_cnt     <= idle_nxt;
    end
  end

`ifdef SC_GRID_EVENT_CNT_EN
  // Saturating count of entries into CRITICAL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crit_events <= 8'd0;
    end else if ((state_nxt == GRID_CRITICAL) && (grid_state != GRID_CRITICAL) &&
                 (crit_events != 8'hFF)) begin
      crit_events <= crit_events + 8'd1;
    end
  end
`endif

endmodule
